// File: rtl/cpu_controller_if.sv
// Bundle of signals between the control unit, the instruction ROM and the datapath.
// The master modport is the controller side; the slave modport is the ROM/datapath side.
interface cpu_controller_if #(
    parameter int PC_W = 7
);
    logic [15:0]     I_Data;
    logic [PC_W-1:0] I_Addr;
    logic [7:0]      D_Addr;
    logic            D_Wr;
    logic [1:0]      RF_s;
    logic [3:0]      RF_W_Addr;
    logic            RF_W_en;
    logic [3:0]      RF_Ra_Addr;
    logic [3:0]      RF_Rb_Addr;
    logic [2:0]      ALU_s0;
    logic [3:0]      State_out;
    logic [15:0]     IR_out;
    logic            Halted;

    modport master (
        input  I_Data,
        output I_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
               RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State_out, IR_out, Halted
    );

    modport slave (
        output I_Data,
        input  I_Addr, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
               RF_Ra_Addr, RF_Rb_Addr, ALU_s0, State_out, IR_out, Halted
    );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle instruction controller: owns PC and IR, sequences fetch/decode/execute
// and drives the datapath controls as Moore outputs of state and IR.
//
// state  | meaning
// INIT   | clear PC and IR after reset
// FETCH  | latch ROM data into IR, advance PC
// DECODE | select execute state from opcode
// NOOP   | no operation (also illegal opcodes)
// LOAD_A | data-memory read in flight
// LOAD_B | write loaded data into RF[a]
// STORE  | write RF[a] to DM[addr8]
// ADD    | RF[c] <= RF[a] + RF[b]
// SUB    | RF[c] <= RF[a] - RF[b]
// HALT   | frozen until reset
module cpu_controller #(
    parameter int PC_W = 7
) (
    input  logic             Clock,
    input  logic             Reset,
    cpu_controller_if.master bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    logic [3:0] opcode;
    logic [3:0] fld_a;
    logic [3:0] fld_b;
    logic [3:0] fld_c;
    logic [7:0] addr8;

    logic [7:0] d_addr;
    logic       d_wr;
    logic [1:0] rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] rf_ra_addr;
    logic [3:0] rf_rb_addr;
    logic [2:0] alu_s0;
    logic       halted;

    assign opcode = ir_q[15:12];
    assign fld_a  = ir_q[11:8];
    assign fld_b  = ir_q[7:4];
    assign fld_c  = ir_q[3:0];
    assign addr8  = ir_q[7:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next state and PC/IR update; PC wraps naturally at its width.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT: begin
                pc_d    = '0;
                ir_d    = '0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = bus.I_Data;
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_NOOP:   state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 2'b00;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s0     = '0;
        halted     = 1'b0;
        case (state_q)
            S_STORE: begin
                rf_ra_addr = fld_a;
                d_addr     = addr8;
                d_wr       = 1'b1;
            end
            S_LOAD_A: begin
                d_addr = addr8;
                rf_s   = 2'b01;
            end
            S_LOAD_B: begin
                d_addr    = addr8;
                rf_s      = 2'b01;
                rf_w_addr = fld_a;
                rf_w_en   = 1'b1;
            end
            S_ADD: begin
                rf_ra_addr = fld_a;
                rf_rb_addr = fld_b;
                alu_s0     = 3'd1;
                rf_w_addr  = fld_c;
                rf_w_en    = 1'b1;
            end
            S_SUB: begin
                rf_ra_addr = fld_a;
                rf_rb_addr = fld_b;
                alu_s0     = 3'd2;
                rf_w_addr  = fld_c;
                rf_w_en    = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.I_Addr     = pc_q;
    assign bus.D_Addr     = d_addr;
    assign bus.D_Wr       = d_wr;
    assign bus.RF_s       = rf_s;
    assign bus.RF_W_Addr  = rf_w_addr;
    assign bus.RF_W_en    = rf_w_en;
    assign bus.RF_Ra_Addr = rf_ra_addr;
    assign bus.RF_Rb_Addr = rf_rb_addr;
    assign bus.ALU_s0     = alu_s0;
    assign bus.State_out  = state_q;
    assign bus.IR_out     = ir_q;
    assign bus.Halted     = halted;

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Control unit for the 16-bit CPU. Owns the program counter (PC), instruction register (IR) and the multi-cycle instruction FSM.
- Fetches 16-bit instructions from a synchronous instruction ROM.
- Drives every control input of the datapath: D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0.
- Sits directly upstream of the datapath. Both blocks share one clock.

Parameters:
- PC_W, 7, PC / instruction-ROM address width (128 words).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- I_Data  in  16  instruction-ROM read data. Registered-address ROM, valid one cycle after address.
- I_Addr  out  PC_W  instruction-ROM address; always equals PC.
- D_Addr  out  8  data-memory address.
- D_Wr  out  1  data-memory write enable.
- RF_s  out  2  write-back mux select: 2'b00 = ALU result, 2'b01 = data-memory read data.
- RF_W_Addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_Addr  out  4  register-file read port A address.
- RF_Rb_Addr  out  4  register-file read port B address.
- ALU_s0  out  3  ALU function select: 0 = pass/zero, 1 = add, 2 = subtract.
- State_out  out  4  current FSM state encoding, for debug.
- IR_out  out  16  current IR contents.
- Halted  out  1  high while in HALT.

Behaviour:
- Instruction format: opcode = IR[15:12]; fields a = IR[11:8], b = IR[7:4], c = IR[3:0]; addr8 = IR[7:0].
- Opcodes:
  - 0000 NOOP.
  - 0001 STORE: DM[addr8] <= RF[a].
  - 0010 LOAD: RF[a] <= DM[addr8].
  - 0011 ADD: RF[c] <= RF[a] + RF[b].
  - 0100 SUB: RF[c] <= RF[a] - RF[b].
  - 0101 HALT.
  - 0110-1111: illegal; executed as NOOP.
- State encodings:
  - INIT = 0, FETCH = 1, DECODE = 2, NOOP = 3, LOAD_A = 4, LOAD_B = 5, STORE = 6, ADD = 7, SUB = 8, HALT = 9.
- Transitions:
  - INIT -> FETCH.
  - FETCH -> DECODE.
  - DECODE -> the opcode's execute state (LOAD -> LOAD_A; illegal -> NOOP).
  - LOAD_A -> LOAD_B -> FETCH.
  - NOOP / STORE / ADD / SUB -> FETCH.
  - HALT -> HALT until Reset.
- Register actions:
  - INIT: PC <= 0; IR <= 0.
  - FETCH: IR <= I_Data; PC <= PC + 1, wrapping modulo 2^PC_W (PC = 127 wraps to 0).
  - PC and IR hold in every other state.
- ROM timing: I_Addr = PC combinationally.
  - Every instruction spends at least 2 cycles after FETCH (DECODE + execute), so I_Data is valid for the current PC at every FETCH.
  - The first FETCH after INIT sees ROM[0].
- Outputs are Moore, decoded from state and IR. Any output not listed for a state is 0.
  - STORE: RF_Ra_Addr = a; D_Addr = addr8; D_Wr = 1.
  - LOAD_A: D_Addr = addr8; RF_s = 01. Covers the data-memory read latency.
  - LOAD_B: D_Addr = addr8; RF_s = 01; RF_W_Addr = a; RF_W_en = 1.
  - ADD: RF_Ra_Addr = a; RF_Rb_Addr = b; ALU_s0 = 1; RF_s = 00; RF_W_Addr = c; RF_W_en = 1.
  - SUB: same as ADD, but ALU_s0 = 2.
  - FETCH, DECODE, NOOP, HALT, INIT: all datapath controls 0.
- Guarantees:
  - At most one of D_Wr and RF_W_en is asserted in any cycle.
  - Each write enable is high for exactly one cycle per instruction.
- Instruction latency in cycles, including FETCH: NOOP 3, STORE 3, ADD 3, SUB 3, LOAD 4.
- Reset:
  - Reset = 1 at any rising edge, including mid-instruction or in HALT, forces state INIT, PC = 0, IR = 0.
  - All control outputs and Halted are 0 in the following cycle.
  - Reset takes priority over all transitions.
  - A pending write in that cycle is suppressed: outputs follow the new state.
- Halted = 1 only in state HALT. PC and IR are frozen there.

Test Plan:
- Reset then ROM[0] = 16'h3123 (ADD) -> sequence INIT, FETCH, DECODE, ADD. In the ADD cycle: Ra = 1, Rb = 2, ALU_s0 = 1, RF_W_Addr = 3, RF_W_en = 1. PC = 1 at DECODE.
- ROM[0] = 16'h2510 (LOAD) -> LOAD_A: D_Addr = 8'h10, RF_s = 01, RF_W_en = 0. LOAD_B: RF_W_Addr = 5, RF_W_en = 1. Back to FETCH after 4 cycles total.
- ROM[0] = 16'h1720 (STORE), ROM[1] = 16'h4987 (SUB) -> STORE cycle: Ra = 7, D_Addr = 8'h20, D_Wr = 1. SUB cycle: ALU_s0 = 2, Ra = 9, Rb = 8, RF_W_Addr = 7. D_Wr and RF_W_en never both high.
- ROM[0] = 16'hF000, ROM[1] = 16'h5000 -> illegal opcode executes as NOOP with all controls 0. Then HALT: Halted = 1, PC stays 2 for 20+ cycles.
- ROM filled with NOOP -> PC counts 0..127, then wraps to 0.
- Assert Reset during LOAD_A and separately during HALT -> next cycle state INIT, PC = 0, IR = 0, no RF_W_en pulse. Execution restarts from ROM[0].
